// File: rtl/mem_pkg.sv
// Shared definitions for the memory stage: access-size codes, writeback
// select codes, ctrl bit positions and the stage FSM encoding.
package mem_pkg;

  localparam logic [2:0] MEM_B  = 3'b000;
  localparam logic [2:0] MEM_H  = 3'b001;
  localparam logic [2:0] MEM_W  = 3'b010;
  localparam logic [2:0] MEM_BU = 3'b100;
  localparam logic [2:0] MEM_HU = 3'b101;

  localparam logic [1:0] WB_ALU  = 2'b00;
  localparam logic [1:0] WB_LOAD = 2'b01;
  localparam logic [1:0] WB_PC   = 2'b10;
  localparam logic [1:0] WB_RSVD = 2'b11;

  localparam int unsigned CTRL_MEM_READ  = 13;
  localparam int unsigned CTRL_MEM_WRITE = 12;
  localparam int unsigned CTRL_F3_HI     = 11;
  localparam int unsigned CTRL_F3_LO     = 9;
  localparam int unsigned CTRL_WB_HI     = 8;
  localparam int unsigned CTRL_WB_LO     = 7;

  typedef enum logic {IDLE, ACCESS} mem_state_t;

  // The reserved select code falls back to the ALU result.
  function automatic logic [31:0] wb_select(input logic [1:0]  sel,
                                            input logic [31:0] alu,
                                            input logic [31:0] load,
                                            input logic [31:0] pc);
    logic [31:0] r;
    case (sel)
      WB_LOAD: r = load;
      WB_PC:   r = pc;
      default: r = alu;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/mem_align.sv
// Byte-lane steering for the data-memory port: store enables/data, load
// extraction with sign/zero extension, and misalignment detection.
module mem_align
  import mem_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr,
  input  logic [31:0] rs2,
  input  logic [31:0] rdata,
  output logic [3:0]  be,
  output logic [31:0] wdata,
  output logic [31:0] load_data,
  output logic        misaligned
);

  logic [31:0] shifted;
  logic [7:0]  byte_val;
  logic [15:0] half_val;

  assign shifted  = rdata >> {addr, 3'b000};
  assign byte_val = shifted[7:0];
  assign half_val = addr[1] ? rdata[31:16] : rdata[15:0];

  // Unknown size codes are handled as word accesses.
  always_comb begin
    be         = 4'b1111;
    wdata      = rs2;
    load_data  = rdata;
    misaligned = 1'b0;
    case (funct3)
      MEM_B, MEM_BU: begin
        be        = 4'b0001 << addr;
        wdata     = {4{rs2[7:0]}};
        load_data = (funct3 == MEM_B) ? {{24{byte_val[7]}}, byte_val}
                                      : {24'b0, byte_val};
      end
      MEM_H, MEM_HU: begin
        be         = addr[1] ? 4'b1100 : 4'b0011;
        wdata      = {2{rs2[15:0]}};
        load_data  = (funct3 == MEM_H) ? {{16{half_val[15]}}, half_val}
                                       : {16'b0, half_val};
        misaligned = addr[0];
      end
      default: begin
        misaligned = (addr != 2'b00);
      end
    endcase
  end

endmodule

// File: rtl/mem_access.sv
// Memory stage: issues loads/stores over a ready/valid port, stalls upstream
// while a request is outstanding, and registers the writeback bundle.
module mem_access
  import mem_pkg::*;
#(
  parameter int REG_WIDTH = 32,
  parameter int REG_COUNT = 32,
  parameter int CTRL_SIZE = 21,
  parameter int REG_BITS  = $clog2(REG_COUNT)
) (
  input  logic                                           clk,
  input  logic                                           rstn,
  input  logic [REG_BITS+1+CTRL_SIZE-7+3*REG_WIDTH-1:0]  exc_mem_reg,
  input  logic                                           in_valid,
  output logic                                           mem_stall,
  output logic                                           dmem_req,
  output logic                                           dmem_we,
  output logic [31:0]                                    dmem_addr,
  output logic [31:0]                                    dmem_wdata,
  output logic [3:0]                                     dmem_be,
  input  logic                                           dmem_ready,
  input  logic [31:0]                                    dmem_rdata,
  output logic [REG_BITS+1+REG_WIDTH-1:0]                mem_wb_reg,
  output logic                                           out_valid,
  output logic                                           misalign
);

  localparam int CW = CTRL_SIZE - 7;
  localparam int BW = REG_BITS + 1 + CW + 3*REG_WIDTH;

  logic [REG_WIDTH-1:0] in_pc, in_rs2, in_alu;
  logic [CW-1:0]        in_ctrl;
  logic                 in_we;
  logic [REG_BITS-1:0]  in_rd;
  logic                 in_read, in_write, in_mem;
  logic [2:0]           in_f3;
  logic [1:0]           in_wb;
  logic [6:0]           unused_ctrl;

  assign in_pc    = exc_mem_reg[REG_WIDTH-1:0];
  assign in_rs2   = exc_mem_reg[2*REG_WIDTH-1:REG_WIDTH];
  assign in_alu   = exc_mem_reg[3*REG_WIDTH-1:2*REG_WIDTH];
  assign in_ctrl  = exc_mem_reg[3*REG_WIDTH+CW-1:3*REG_WIDTH];
  assign in_we    = exc_mem_reg[3*REG_WIDTH+CW];
  assign in_rd    = exc_mem_reg[BW-1:3*REG_WIDTH+CW+1];
  assign in_read  = in_ctrl[CTRL_MEM_READ];
  assign in_write = in_ctrl[CTRL_MEM_WRITE];
  assign in_mem   = in_read | in_write;
  assign in_f3    = in_ctrl[CTRL_F3_HI:CTRL_F3_LO];
  assign in_wb    = in_ctrl[CTRL_WB_HI:CTRL_WB_LO];
  assign unused_ctrl = in_ctrl[6:0];

  mem_state_t state, state_next;

  logic [REG_BITS-1:0]  acc_rd;
  logic                 acc_we;
  logic [2:0]           acc_f3;
  logic [1:0]           acc_wb;
  logic [REG_WIDTH-1:0] acc_alu, acc_pc;

  logic [2:0]  al_f3;
  logic [1:0]  al_addr;
  logic [3:0]  al_be;
  logic [31:0] al_wdata, al_load;
  logic        al_mis;
  logic        mis_hit;

  // One aligner serves both phases: issue-side lanes in IDLE, load
  // extraction from the held request in ACCESS.
  assign al_f3   = (state == ACCESS) ? acc_f3 : in_f3;
  assign al_addr = (state == ACCESS) ? acc_alu[1:0] : in_alu[1:0];
  assign mis_hit = in_mem & al_mis;

  mem_align u_align (
    .funct3     (al_f3),
    .addr       (al_addr),
    .rs2        (in_rs2),
    .rdata      (dmem_rdata),
    .be         (al_be),
    .wdata      (al_wdata),
    .load_data  (al_load),
    .misaligned (al_mis)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:   if (in_valid && in_mem && !al_mis) state_next = ACCESS;
      ACCESS: if (dmem_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    dmem_req  = 1'b0;
    mem_stall = 1'b0;
    if (state == ACCESS) begin
      dmem_req  = 1'b1;
      mem_stall = 1'b1;
    end
  end

  assign dmem_addr = {acc_alu[31:2], 2'b00};

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      mem_wb_reg <= '0;
      out_valid  <= 1'b0;
      misalign   <= 1'b0;
      dmem_we    <= 1'b0;
      dmem_be    <= '0;
      dmem_wdata <= '0;
      acc_rd     <= '0;
      acc_we     <= 1'b0;
      acc_f3     <= '0;
      acc_wb     <= '0;
      acc_alu    <= '0;
      acc_pc     <= '0;
    end else begin
      misalign <= 1'b0;
      case (state)
        IDLE: begin
          if (!in_valid) begin
            out_valid <= 1'b0;
          end else if (in_mem && !al_mis) begin
            out_valid  <= 1'b0;
            dmem_we    <= in_write;
            dmem_be    <= in_write ? al_be : 4'b0000;
            dmem_wdata <= al_wdata;
            acc_rd     <= in_rd;
            acc_we     <= in_we & ~in_write;
            acc_f3     <= in_f3;
            acc_wb     <= in_wb;
            acc_alu    <= in_alu;
            acc_pc     <= in_pc;
          end else begin
            mem_wb_reg <= {in_rd, in_we & ~in_mem, wb_select(in_wb, in_alu, '0, in_pc)};
            out_valid  <= 1'b1;
            misalign   <= mis_hit;
          end
        end
        ACCESS: begin
          if (dmem_ready) begin
            mem_wb_reg <= {acc_rd, acc_we, wb_select(acc_wb, acc_alu, al_load, acc_pc)};
            out_valid  <= 1'b1;
          end else begin
            out_valid  <= 1'b0;
          end
        end
        default: out_valid <= 1'b0;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access.sv
// Scoreboard bench for mem_access: expected writeback bundles are queued at
// issue and compared whenever out_valid is seen.
module tb_mem_access;

  logic         clk = 1'b0;
  logic         rstn = 1'b0;
  logic [115:0] exc_mem_reg = '0;
  logic         in_valid = 1'b0;
  logic         mem_stall, dmem_req, dmem_we;
  logic [31:0]  dmem_addr, dmem_wdata;
  logic [3:0]   dmem_be;
  logic         dmem_ready = 1'b0;
  logic [31:0]  dmem_rdata = '0;
  logic [37:0]  mem_wb_reg;
  logic         out_valid, misalign;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [37:0] wb;
    logic [37:0] mask;
    logic        mis;
  } exp_t;
  exp_t sb[$];

  localparam logic [37:0] ALL  = '1;
  localparam logic [37:0] HDR  = {6'h3f, 32'h0};

  always #5 clk = ~clk;

  mem_access dut (
    .clk         (clk),
    .rstn        (rstn),
    .exc_mem_reg (exc_mem_reg),
    .in_valid    (in_valid),
    .mem_stall   (mem_stall),
    .dmem_req    (dmem_req),
    .dmem_we     (dmem_we),
    .dmem_addr   (dmem_addr),
    .dmem_wdata  (dmem_wdata),
    .dmem_be     (dmem_be),
    .dmem_ready  (dmem_ready),
    .dmem_rdata  (dmem_rdata),
    .mem_wb_reg  (mem_wb_reg),
    .out_valid   (out_valid),
    .misalign    (misalign)
  );

  task automatic check_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  function automatic logic [115:0] mk(input logic [4:0] rd, input logic we,
                                      input logic mr, input logic mw,
                                      input logic [2:0] f3, input logic [1:0] wb,
                                      input logic [31:0] alu, input logic [31:0] rs2,
                                      input logic [31:0] pc);
    logic [13:0] c;
    c = {mr, mw, f3, wb, 7'b0};
    return {rd, we, c, alu, rs2, pc};
  endfunction

  always @(negedge clk) begin
    if (rstn && out_valid) begin
      if (sb.size() == 0) begin
        check_val("unexpected_out_valid", 1, 0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check_val("mem_wb_reg", mem_wb_reg & e.mask, e.wb & e.mask);
        check_val("misalign", misalign, e.mis);
      end
    end
  end

  // Drive one bundle at a negedge; if a request is expected, act as the
  // memory, granting after 'waits' stall cycles.
  task automatic issue(input string tag, input logic [115:0] b,
                       input int unsigned waits, input logic [31:0] rdata,
                       input bit e_req, input logic [31:0] e_addr,
                       input logic [3:0] e_be, input logic [31:0] e_wd,
                       input bit e_we, input logic [37:0] e_wb,
                       input logic [37:0] mask, input bit e_mis);
    exp_t e;
    e.wb = e_wb; e.mask = mask; e.mis = e_mis;
    sb.push_back(e);
    exc_mem_reg = b;
    in_valid    = 1'b1;
    @(posedge clk); @(negedge clk);
    if (e_req) begin
      for (int unsigned i = 0; i <= waits; i++) begin
        check_val({tag, ".req"},   dmem_req, 1);
        check_val({tag, ".stall"}, mem_stall, 1);
        check_val({tag, ".addr"},  dmem_addr, e_addr);
        check_val({tag, ".be"},    dmem_be, e_be);
        check_val({tag, ".we"},    dmem_we, e_we);
        if (e_we) check_val({tag, ".wdata"}, dmem_wdata, e_wd);
        if (i == waits) begin
          dmem_ready = 1'b1;
          dmem_rdata = rdata;
        end
        @(posedge clk); @(negedge clk);
      end
      dmem_ready = 1'b0;
    end
    check_val({tag, ".req_idle"},   dmem_req, 0);
    check_val({tag, ".stall_idle"}, mem_stall, 0);
    in_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    #12;
    check_val("rst.req",   dmem_req, 0);
    check_val("rst.stall", mem_stall, 0);
    check_val("rst.valid", out_valid, 0);
    check_val("rst.wb",    mem_wb_reg, 0);
    check_val("rst.mis",   misalign, 0);
    @(negedge clk); rstn = 1'b1;
    @(negedge clk);

    issue("alu", mk(5, 1, 0, 0, 3'b000, 2'b00, 32'h0000_1234, 32'h0, 32'h0),
          0, 0, 0, 0, 0, 0, 0, {5'd5, 1'b1, 32'h1234}, ALL, 0);
    issue("sw", mk(3, 1, 0, 1, 3'b010, 2'b00, 32'h100, 32'hDEAD_BEEF, 32'h0),
          2, 0, 1, 32'h100, 4'b1111, 32'hDEAD_BEEF, 1, {5'd3, 1'b0, 32'h100}, ALL, 0);
    issue("lb", mk(7, 1, 1, 0, 3'b000, 2'b01, 32'h103, 32'h0, 32'h0),
          0, 32'h80FF_0000, 1, 32'h100, 4'b0000, 0, 0, {5'd7, 1'b1, 32'hFFFF_FF80}, ALL, 0);
    issue("lbu", mk(8, 1, 1, 0, 3'b100, 2'b01, 32'h103, 32'h0, 32'h0),
          0, 32'h80FF_0000, 1, 32'h100, 4'b0000, 0, 0, {5'd8, 1'b1, 32'h0000_0080}, ALL, 0);
    issue("lhu", mk(9, 1, 1, 0, 3'b101, 2'b01, 32'h102, 32'h0, 32'h0),
          0, 32'h80FF_0000, 1, 32'h100, 4'b0000, 0, 0, {5'd9, 1'b1, 32'h0000_80FF}, ALL, 0);
    issue("lh", mk(10, 1, 1, 0, 3'b001, 2'b01, 32'h102, 32'h0, 32'h0),
          1, 32'h80FF_0000, 1, 32'h100, 4'b0000, 0, 0, {5'd10, 1'b1, 32'hFFFF_80FF}, ALL, 0);
    issue("sh", mk(11, 1, 0, 1, 3'b001, 2'b00, 32'h102, 32'h0000_ABCD, 32'h0),
          0, 0, 1, 32'h100, 4'b1100, 32'hABCD_ABCD, 1, {5'd11, 1'b0, 32'h102}, ALL, 0);
    issue("sb", mk(12, 0, 0, 1, 3'b000, 2'b00, 32'h201, 32'h1234_5678, 32'h0),
          0, 0, 1, 32'h200, 4'b0010, 32'h7878_7878, 1, {5'd12, 1'b0, 32'h201}, ALL, 0);
    issue("lw_mis", mk(13, 1, 1, 0, 3'b010, 2'b01, 32'h101, 32'h0, 32'h0),
          0, 0, 0, 0, 0, 0, 0, {5'd13, 1'b0, 32'h0}, HDR, 1);
    issue("lw", mk(14, 1, 1, 0, 3'b010, 2'b01, 32'h104, 32'h0, 32'h0),
          1, 32'hCAFE_F00D, 1, 32'h104, 4'b0000, 0, 0, {5'd14, 1'b1, 32'hCAFE_F00D}, ALL, 0);
    issue("jal", mk(1, 1, 0, 0, 3'b000, 2'b10, 32'h999, 32'h0, 32'h44),
          0, 0, 0, 0, 0, 0, 0, {5'd1, 1'b1, 32'h44}, ALL, 0);
    issue("wb_rsvd", mk(2, 1, 0, 0, 3'b000, 2'b11, 32'h777, 32'h0, 32'h44),
          0, 0, 0, 0, 0, 0, 0, {5'd2, 1'b1, 32'h777}, ALL, 0);
    issue("rw_both", mk(15, 1, 1, 1, 3'b010, 2'b01, 32'h200, 32'h11, 32'h0),
          0, 0, 1, 32'h200, 4'b1111, 32'h11, 1, {5'd15, 1'b0, 32'h0}, HDR, 0);

    // Abandon an outstanding load with reset; no writeback is expected.
    exc_mem_reg = mk(16, 1, 1, 0, 3'b010, 2'b01, 32'h300, 32'h0, 32'h0);
    in_valid = 1'b1;
    @(posedge clk); @(negedge clk);
    check_val("rstacc.req_before", dmem_req, 1);
    #2 rstn = 1'b0;
    #1;
    check_val("rstacc.req",   dmem_req, 0);
    check_val("rstacc.stall", mem_stall, 0);
    check_val("rstacc.valid", out_valid, 0);
    in_valid = 1'b0;
    @(negedge clk); rstn = 1'b1;
    @(negedge clk);

    issue("alu_after_rst", mk(4, 1, 0, 0, 3'b000, 2'b00, 32'h0000_5A5A, 32'h0, 32'h0),
          0, 0, 0, 0, 0, 0, 0, {5'd4, 1'b1, 32'h5A5A}, ALL, 0);
    @(negedge clk);
    check_val("sb.drain", sb.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
